// File: rtl/lpc_tap_sequencer_if.sv
// Sample/tap/MAC/result handshake bundle between the LPC tap sequencer (slave side)
// and the upstream sample source plus downstream MAC consumer (master side).
interface lpc_tap_sequencer_if #(
  parameter int unsigned ORDER = 10,
  parameter int unsigned AW    = 4
) ();
  logic           in_valid;
  logic           in_ready;
  logic           shift_en;
  logic [ORDER:0] tap;
  logic [AW-1:0]  coef_addr;
  logic           mac_clr;
  logic           mac_en;
  logic           mac_last;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_valid, out_ready,
    input  in_ready, shift_en, tap, coef_addr, mac_clr, mac_en, mac_last, out_valid
  );

  modport slave (
    input  in_valid, out_ready,
    output in_ready, shift_en, tap, coef_addr, mac_clr, mac_en, mac_last, out_valid
  );
endinterface

// File: rtl/lpc_tap_sequencer.sv
// Sweeps the one-hot tap select over lags 0..order for each sample, drives the MAC and
// coefficient address, shifts the delay line after the sweep and hands off the result.
module lpc_tap_sequencer #(
  parameter int unsigned ORDER   = 10,
  parameter int unsigned AW      = 4,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       cfg_order,
  lpc_tap_sequencer_if.slave  bus,
  output logic                busy
);

  localparam int unsigned DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StSweep, StDrain, StOut} state_e;

  state_e         state_q;
  logic [AW-1:0]  k_q;
  logic [AW-1:0]  ord_q;
  logic [DW-1:0]  d_q;
  logic [ORDER:0] tap_q;
  logic [AW-1:0]  coef_q;
  logic           clr_q;
  logic           en_q;
  logic           last_q;
  logic           ready_q;
  logic           outv_q;

  logic [AW-1:0]  ord_start;
  logic           start;

  function automatic logic [AW-1:0] clamp_order(input logic [AW-1:0] v);
    if (v == '0) return AW'(1);
    if (v > AW'(ORDER)) return AW'(ORDER);
    return v;
  endfunction

  assign ord_start = clamp_order(cfg_order);
  // New sweep from IDLE, or straight from OUT when the next sample is already waiting.
  assign start = bus.in_valid &
                 ((state_q == StIdle) | ((state_q == StOut) & bus.out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      ord_q   <= '0;
      d_q     <= '0;
      tap_q   <= '0;
      coef_q  <= '0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      outv_q  <= 1'b0;
    end else if (start) begin
      state_q <= StSweep;
      ord_q   <= ord_start;
      k_q     <= '0;
      tap_q   <= (ORDER + 1)'(1);
      coef_q  <= '0;
      clr_q   <= 1'b1;
      en_q    <= 1'b1;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      outv_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StSweep: begin
          if (k_q == ord_q) begin
            state_q <= StDrain;
            d_q     <= '0;
            tap_q   <= '0;
            coef_q  <= '0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
          end else begin
            k_q     <= k_q + AW'(1);
            tap_q   <= tap_q << 1;
            coef_q  <= k_q + AW'(1);
            clr_q   <= 1'b0;
            last_q  <= (k_q + AW'(1)) == ord_q;
            ready_q <= (k_q + AW'(1)) == ord_q;
          end
        end
        StDrain: begin
          d_q <= d_q + DW'(1);
          if (d_q == DW'(MAC_LAT - 1)) begin
            state_q <= StOut;
            outv_q  <= 1'b1;
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
            outv_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.tap       = tap_q;
  assign bus.coef_addr = coef_q;
  assign bus.mac_clr   = clr_q;
  assign bus.mac_en    = en_q;
  assign bus.mac_last  = last_q;
  assign bus.in_ready  = ready_q;
  assign bus.out_valid = outv_q;
  assign bus.shift_en  = bus.in_valid & ready_q;
  assign busy          = state_q != StIdle;

endmodule

// File: tb/tb_lpc_tap_sequencer.sv
// Random-stimulus bench: a timeline model of each sample transaction predicts every output,
// and a delay line plus MAC driven by the DUT's controls is checked against sum a_k*x[n-k].
module tb_lpc_tap_sequencer;

  localparam int ORDER   = 10;
  localparam int AW      = 4;
  localparam int MAC_LAT = 2;
  localparam int NCYC    = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfg_order;
  logic          busy;

  lpc_tap_sequencer_if #(.ORDER(ORDER), .AW(AW)) bus ();

  lpc_tap_sequencer #(
    .ORDER  (ORDER),
    .AW     (AW),
    .MAC_LAT(MAC_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_order(cfg_order),
    .bus      (bus),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference transaction state: pos is the cycle index within the current transaction
  // (-1 when idle); lags 0..mord sweep, then MAC_LAT drain cycles, then the result cycle(s).
  int pos  = -1;
  int mord = 0;
  int hist[$];
  int coef_a[16];
  int ref_e = 0;
  bit have_ref = 1'b0;
  bit out_checked = 1'b0;

  // Downstream delay line and MAC, fed only by the DUT's outputs.
  int din = 1;
  int dl[ORDER+1];
  int acc = 0;
  logic [ORDER:0] r_tap = '0;
  logic [AW-1:0]  r_coef = '0;
  logic r_en = 1'b0, r_clr = 1'b0, r_shift = 1'b0;
  bit accepted_dut = 1'b0;

  function automatic int clamp_ref(input int v);
    if (v < 1) return 1;
    if (v > ORDER) return ORDER;
    return v;
  endfunction

  task automatic step();
    int sel;
    if (r_en) begin
      sel = 0;
      for (int k = 0; k <= ORDER; k++) if (r_tap[k]) sel = (k == 0) ? din : dl[k];
      acc = (r_clr ? 0 : acc) + coef_a[r_coef] * sel;
    end
    accepted_dut = r_shift && !rst;
    if (accepted_dut) begin
      for (int k = ORDER; k >= 2; k--) dl[k] = dl[k-1];
      dl[1] = din;
    end

    if (rst) begin
      pos  = -1;
      mord = 0;
    end else if (pos < 0) begin
      if (bus.in_valid) begin
        mord = clamp_ref(int'(cfg_order));
        pos  = 0;
        out_checked = 1'b0;
      end
    end else if (pos <= mord + MAC_LAT) begin
      if (pos == mord && bus.in_valid) begin
        hist.push_front(din);
        ref_e = 0;
        for (int k = 0; k <= mord; k++) if (k < hist.size()) ref_e += coef_a[k] * hist[k];
        have_ref = 1'b1;
      end
      pos++;
    end else if (bus.out_ready) begin
      if (bus.in_valid) begin
        mord = clamp_ref(int'(cfg_order));
        pos  = 0;
        out_checked = 1'b0;
      end else begin
        pos = -1;
      end
    end
  endtask

  task automatic drive(input int cyc);
    rst = (cyc < 2) || ($urandom_range(0, 79) == 0);
    if (accepted_dut) begin
      din++;
      bus.in_valid = ($urandom_range(0, 3) != 0);
    end else if (!bus.in_valid) begin
      bus.in_valid = ($urandom_range(0, 2) != 0);
    end
    if ($urandom_range(0, 3) == 0) cfg_order = AW'($urandom_range(0, 15));
    bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic compare();
    bit sw, exp_ready;
    sw        = (pos >= 0) && (pos <= mord);
    exp_ready = sw && (pos == mord);
    check_eq("tap",       32'(bus.tap),       sw ? 32'(1) << pos : 32'd0);
    check_eq("mac_en",    32'(bus.mac_en),    32'(sw));
    check_eq("mac_clr",   32'(bus.mac_clr),   32'(sw && pos == 0));
    check_eq("mac_last",  32'(bus.mac_last),  32'(exp_ready));
    check_eq("in_ready",  32'(bus.in_ready),  32'(exp_ready));
    check_eq("shift_en",  32'(bus.shift_en),  32'(exp_ready && bus.in_valid));
    check_eq("out_valid", 32'(bus.out_valid), 32'(pos == mord + MAC_LAT + 1));
    check_eq("busy",      32'(busy),          32'(pos >= 0));
    check_eq("tap_onehot0", 32'($onehot0(bus.tap)), 32'd1);
    if (sw) check_eq("coef_addr", 32'(bus.coef_addr), 32'(pos));
    if (pos == mord + MAC_LAT + 1 && !out_checked && have_ref) begin
      check_eq("mac_result", 32'(acc), 32'(ref_e));
      out_checked = 1'b1;
    end
    r_tap   = bus.tap;
    r_coef  = bus.coef_addr;
    r_en    = bus.mac_en;
    r_clr   = bus.mac_clr;
    r_shift = bus.shift_en;
  endtask

  always @(negedge clk) begin
    if (!rst) assert (!(bus.mac_en && !bus.in_valid)) else $error("in_valid dropped mid-sweep");
  end

  initial begin
    for (int i = 0; i < 16; i++) coef_a[i] = int'($urandom_range(0, 14)) - 7;
    for (int i = 0; i <= ORDER; i++) dl[i] = 0;
    rst           = 1'b1;
    cfg_order     = AW'(10);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      step();
      #1;
      drive(c);
      @(negedge clk);
      compare();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lpc_tap_sequencer.md
Name: lpc_tap_sequencer

Overview:
- Controller for the 11-position one-hot tapped sample delay line (bypass plus 10 delayed taps) in the LPC analysis path.
- For each incoming sample x[n], sweeps the tap select from lag 0 to the programmed order. In the same cycle it issues the matching coefficient address and MAC enables, so the downstream MAC computes e[n] = sum a_k·x[n-k].
- Shifts the sample into the delay line only after the sweep, then presents a result-valid handshake to the consumer.

Parameters:
- ORDER, 10, maximum predictor order; the tap bus is ORDER+1 bits wide.
- AW, 4, coefficient address width; must satisfy 2^AW > ORDER.
- MAC_LAT, 2, cycles from a mac_last cycle until the MAC result is valid; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_order  in  AW  requested order; sampled when a sweep starts.
- in_valid  in  1  upstream sample valid. Upstream holds din stable while in_valid=1 and not accepted.
- in_ready  out  1  sample accepted this cycle.
- shift_en  out  1  delay-line shift strobe; equals in_valid & in_ready.
- tap  out  ORDER+1  one-hot tap select; bit0 is bypass (current din), bit k is x[n-k].
- coef_addr  out  AW  coefficient ROM/RAM address, equal to the current lag k.
- mac_clr  out  1  clear the accumulator before this product (lag 0).
- mac_en  out  1  accumulate tap·coef this cycle.
- mac_last  out  1  final product of the sweep.
- out_valid  out  1  MAC result valid for the consumer.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, SWEEP, DRAIN, OUT. Counters: lag k (AW bits), drain count d. Register ord_q.
- All outputs decode from the registered state and counters only. The sole exception is shift_en, which is in_ready & in_valid.
- Reset:
  - state=IDLE, k=0, d=0, ord_q=0.
  - All outputs are 0, including tap=0 (the delay line then outputs zero).
- IDLE:
  - tap=0, in_ready=0.
  - If in_valid=1: ord_q ← clamp(cfg_order), k←0, next state SWEEP.
  - Clamp rule: 0→1, >ORDER→ORDER.
  - The sample is not consumed here.
- SWEEP (cycle with lag k):
  - tap = 1<<k; coef_addr=k; mac_en=1; mac_clr=(k==0); mac_last=(k==ord_q).
  - If k<ord_q: k←k+1.
  - If k==ord_q: in_ready=1, so shift_en=1 because in_valid is still held. Then d←0 and next state DRAIN.
  - The sweep lasts exactly ord_q+1 cycles. Taps above ord_q are never selected.
- Shift ordering: the shift occurs at the end of the last sweep cycle. Every lag therefore reads x[n-k] relative to the sample currently on din.
- Protocol violation: if in_valid drops during SWEEP, the sweep completes unchanged and shift_en stays 0 (in_ready=1 but in_valid=0). A bench assertion flags this case; RTL does not recover from it.
- DRAIN:
  - tap=0, MAC controls 0.
  - d increments each cycle. After MAC_LAT cycles, next state OUT.
- OUT:
  - out_valid=1, held until out_ready=1. A stall may last any number of cycles.
  - On out_ready=1 with in_valid=1: ord_q ← clamp(cfg_order), k←0, next state SWEEP. This is the back-to-back path, with no IDLE cycle.
  - On out_ready=1 with in_valid=0: next state IDLE.
- Throughput: one sample per ord_q+1+MAC_LAT+1 cycles with no backpressure.
- Changes to cfg_order mid-sweep have no effect until the next start.
- Reset mid-operation: next cycle is IDLE with all outputs 0. The in-flight sample is not shifted and is not acknowledged, so upstream re-presents it. A pending out_valid is dropped.
- Invariants:
  - tap is zero-hot or one-hot at all times.
  - mac_en=1 implies exactly one tap bit is set.
  - in_ready=1 only in the last SWEEP cycle.

Test Plan:
- ORDER=10, MAC_LAT=2, cfg_order=10, in_valid raised at cycle 0, out_ready=1 -> cycles 1..11 show tap 0x001,0x002,…,0x400 and coef_addr 0..10; mac_clr only at cycle 1; mac_last and shift_en only at cycle 11; out_valid at cycle 14 for one cycle; IDLE at 15.
- cfg_order=3; separately cfg_order=0 and cfg_order=15 -> sweeps of 4, 2 and 11 cycles respectively; tap never exceeds 0x008 for order 3; shift_en in the final sweep cycle.
- Hold out_ready=0 for 5 cycles in OUT -> out_valid stays 1 for 6 cycles; no tap activity; in_ready stays 0 despite in_valid=1.
- Continuous in_valid, out_ready=1, cfg_order=10 -> SWEEP restarts the cycle after OUT; shift_en every 14 cycles. A reference MAC model fed ramp samples 1,2,3,… matches sum a_k·x[n-k], with zeros for the unfilled history.
- Assert rst at sweep lag 5 -> next cycle tap=0, busy=0, no shift_en; re-presented sample completes a full sweep from lag 0.
- Change cfg_order from 10 to 2 mid-sweep -> current sweep still ends at lag 10; next sweep ends at lag 2.
